// File: rtl/iol_ctrl_pkg.sv
// Shared types and default timing for the x2 gearing
// start-up / word-alignment controller.
package iol_ctrl_pkg;

  typedef enum logic [2:0] {
    HOLD,
    STOP,
    RELEASE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } state_e;

  localparam int         DEF_DATA_W        = 4;
  localparam logic [3:0] DEF_TRAIN_PATTERN = 4'b1100;
  localparam int         DEF_RST_CYCLES    = 8;
  localparam int         DEF_STOP_CYCLES   = 4;
  localparam int         DEF_SETTLE_CYCLES = 8;
  localparam int         DEF_MATCH_COUNT   = 16;
  localparam int         DEF_MAX_SLIPS     = 4;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iol_word_sync.sv
// Two-flop synchronizer for the deserialized word plus a
// registered compare against the training pattern.
module iol_word_sync
  import iol_ctrl_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] PATTERN = DEF_TRAIN_PATTERN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] word_i,
  output logic              match_o
);

  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;
  logic              match_q, match_d;

  always_comb begin
    s1_d    = word_i;
    s2_d    = s1_q;
    match_d = (s2_q == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      match_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/iddrx2_align_ctrl.sv
// GDDR x2 sync sequence and ALIGNWD word-alignment trainer.
// All outputs are registered and decoded from the next state.
module iddrx2_align_ctrl
  import iol_ctrl_pkg::*;
#(
  parameter int                DATA_W        = DEF_DATA_W,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                RST_CYCLES    = DEF_RST_CYCLES,
  parameter int                STOP_CYCLES   = DEF_STOP_CYCLES,
  parameter int                SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int                MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int                MAX_SLIPS     = DEF_MAX_SLIPS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           retrain,
  input  logic [DATA_W-1:0]              word_i,
  output logic                           gddr_rst,
  output logic                           eclk_stop,
  output logic                           alignwd,
  output logic                           locked,
  output logic                           fail,
  output logic [$clog2(MAX_SLIPS+1)-1:0] slip_cnt
);

  localparam int SLIP_W = $clog2(MAX_SLIPS + 1);
  localparam int CNT_W  =
    $clog2(max3(RST_CYCLES, STOP_CYCLES, SETTLE_CYCLES) + 1);
  localparam int MCNT_W = $clog2(MATCH_COUNT + 1);

  localparam logic [CNT_W-1:0]  RST_INIT = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0]  RST_LD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STOP_LD  = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETL_LD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [MCNT_W-1:0] MC_LAST  = MCNT_W'(MATCH_COUNT - 1);
  localparam logic [SLIP_W-1:0] SLIP_MAX = SLIP_W'(MAX_SLIPS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic [SLIP_W-1:0] slip_q, slip_d;
  logic              gddr_rst_q, gddr_rst_d;
  logic              eclk_stop_q, eclk_stop_d;
  logic              alignwd_q, alignwd_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;
  logic              match;
  logic              cnt_done;

  iol_word_sync #(
    .DATA_W  (DATA_W),
    .PATTERN (TRAIN_PATTERN)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .word_i  (word_i),
    .match_o (match)
  );

  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_done ? cnt_q : cnt_q - 1'b1;
    mcnt_d  = mcnt_q;
    slip_d  = slip_q;
    if (retrain) begin
      state_d = HOLD;
      cnt_d   = RST_LD;
      mcnt_d  = '0;
      slip_d  = '0;
    end else begin
      unique case (state_q)
        HOLD: if (cnt_done) begin
          state_d = STOP;
          cnt_d   = STOP_LD;
        end
        STOP: if (cnt_done) begin
          state_d = RELEASE;
          cnt_d   = STOP_LD;
        end
        RELEASE: if (cnt_done) begin
          state_d = SETTLE;
          cnt_d   = SETL_LD;
          mcnt_d  = '0;
        end
        SETTLE: if (cnt_done) begin
          state_d = CHECK;
        end
        CHECK: begin
          if (match) begin
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_q == MC_LAST) state_d = LOCKED;
          end else if (slip_q < SLIP_MAX) begin
            state_d = SLIP;
          end else begin
            state_d = FAIL;
          end
        end
        SLIP: begin
          state_d = SETTLE;
          cnt_d   = SETL_LD;
          mcnt_d  = '0;
          if (slip_q < SLIP_MAX) slip_d = slip_q + 1'b1;
        end
        LOCKED: state_d = LOCKED;
        FAIL:   state_d = FAIL;
      endcase
    end
    gddr_rst_d  = (state_d == HOLD) || (state_d == STOP);
    eclk_stop_d = (state_d == STOP) || (state_d == RELEASE);
    alignwd_d   = (state_d == SLIP);
    locked_d    = (state_d == LOCKED);
    fail_d      = (state_d == FAIL);
  end

  // Reset loads the full hold count: the first edge after rst
  // falls is the first HOLD cycle of the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      cnt_q       <= RST_INIT;
      mcnt_q      <= '0;
      slip_q      <= '0;
      gddr_rst_q  <= 1'b1;
      eclk_stop_q <= 1'b0;
      alignwd_q   <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcnt_q      <= mcnt_d;
      slip_q      <= slip_d;
      gddr_rst_q  <= gddr_rst_d;
      eclk_stop_q <= eclk_stop_d;
      alignwd_q   <= alignwd_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign gddr_rst  = gddr_rst_q;
  assign eclk_stop = eclk_stop_q;
  assign alignwd   = alignwd_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign slip_cnt  = slip_q;

endmodule
